// File: rtl/mul_seq_unit.sv
// Iterative shift-add multiplier with a valid/ready front end, returning the low or high
// half of the exact product. Supports signed, unsigned and mixed-sign operand modes.
module mul_seq_unit #(
    parameter int DWIDTH = 32,
    parameter int STEP   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        mul_op,
    input  logic [DWIDTH-1:0] alu_a,
    input  logic [DWIDTH-1:0] alu_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] alu_res,
    output logic              busy
);
    localparam int N  = DWIDTH / STEP;
    localparam int CW = $clog2(N) + 1;
    localparam int PW = 2 * DWIDTH;
    localparam logic [DWIDTH-1:0] ONE_D = DWIDTH'(1);
    localparam logic [PW-1:0]     ONE_P = PW'(1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic [1:0] op;
        logic       neg;
    } req_t;

    state_t            state;
    req_t              req;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     addend;
    logic [DWIDTH-1:0] mag_b;

    logic              a_sgn, b_sgn;
    logic [DWIDTH-1:0] a_mag, b_mag;
    logic [STEP-1:0]   digit;
    logic [PW-1:0]     pp, acc_nx, prod_fin;
    logic [DWIDTH-1:0] res_sel;
    logic              last_iter;

    // Operand a is signed for every mode but MULHU; b only for MUL/MULH.
    always_comb begin
        a_sgn = (mul_op != 2'b11) && alu_a[DWIDTH-1];
        b_sgn = !mul_op[1] && alu_b[DWIDTH-1];
        a_mag = a_sgn ? (~alu_a + ONE_D) : alu_a;
        b_mag = b_sgn ? (~alu_b + ONE_D) : alu_b;
    end

    // Partial product for this iteration: addend already sits at the digit's weight.
    always_comb begin
        digit = mag_b[STEP-1:0];
        pp    = '0;
        for (int i = 0; i < STEP; i++) begin
            if (digit[i]) pp = pp + (addend << i);
        end
        acc_nx    = acc + pp;
        prod_fin  = req.neg ? (~acc_nx + ONE_P) : acc_nx;
        res_sel   = (req.op == 2'b00) ? prod_fin[DWIDTH-1:0] : prod_fin[PW-1:DWIDTH];
        last_iter = (cnt == CW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            req     <= '0;
            cnt     <= '0;
            acc     <= '0;
            addend  <= '0;
            mag_b   <= '0;
            alu_res <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state   <= BUSY;
                        req.op  <= mul_op;
                        req.neg <= a_sgn ^ b_sgn;
                        addend  <= {{DWIDTH{1'b0}}, a_mag};
                        mag_b   <= b_mag;
                        acc     <= '0;
                        cnt     <= '0;
                    end
                end
                BUSY: begin
                    acc    <= acc_nx;
                    addend <= addend << STEP;
                    mag_b  <= mag_b >> STEP;
                    cnt    <= cnt + CW'(1);
                    if (last_iter) begin
                        alu_res <= res_sel;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);
endmodule

// File: tb/tb_mul_seq_unit.sv
// Drives two multiplier instances (STEP=1 and STEP=4) with shared operands; a scoreboard
// checks results, latency, busy and hold-under-backpressure against a plain-arithmetic model.
module tb_mul_seq_unit;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [1:0]    mul_op;
    logic [DW-1:0] alu_a, alu_b;
    logic          iv[2], ordy[2], ir[2], ov[2], bsy[2];
    logic [DW-1:0] res[2];
    logic          ordy_force[2];
    bit            rnd_ordy;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mul_seq_unit #(.DWIDTH(DW), .STEP(g == 0 ? 1 : 4)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(iv[g]), .in_ready(ir[g]),
            .mul_op(mul_op), .alu_a(alu_a), .alu_b(alu_b),
            .out_valid(ov[g]), .out_ready(ordy[g]), .alu_res(res[g]), .busy(bsy[g])
        );
    end

    int checks = 0, failures = 0;

    task automatic chk(string name, int inst, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d: got %h expected %h (cycle %0d)", name, inst, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] model(logic [1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
        logic signed [2*DW+1:0] ea, eb, p;
        ea = (op != 2'b11) ? {{(DW+2){a[DW-1]}}, a} : {{(DW+2){1'b0}}, a};
        eb = (op[1] == 1'b0) ? {{(DW+2){b[DW-1]}}, b} : {{(DW+2){1'b0}}, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[DW-1:0] : p[2*DW-1:DW];
    endfunction

    // Scoreboard: one ring of expected results per instance.
    logic [DW-1:0] e_res[2][256];
    int            e_cyc[2][256];
    int            wp[2], rp[2];
    bit            seen[2], hold[2];
    logic [DW-1:0] prev_res[2];

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) ordy[g] = rnd_ordy ? ($urandom_range(0, 3) != 0) : ordy_force[g];
    end

    always begin
        @(negedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            int n;
            n = (g == 0) ? 32 : 8;
            if (!rst_n) begin
                rp[g] = wp[g]; seen[g] = 0; hold[g] = 0;
                continue;
            end
            if (hold[g]) begin
                chk("hold_valid", g, 64'(ov[g]), 64'd1);
                chk("hold_res", g, 64'(res[g]), 64'(prev_res[g]));
                chk("hold_in_ready", g, 64'(ir[g]), 64'd0);
            end
            if (ov[g]) begin
                if (rp[g] == wp[g]) chk("spurious_valid", g, 64'(ov[g]), 64'd0);
                else begin
                    if (!seen[g]) begin
                        chk("latency", g, 64'(cyc - e_cyc[g][rp[g] % 256]), 64'(n + 1));
                        chk("result", g, 64'(res[g]), 64'(e_res[g][rp[g] % 256]));
                        seen[g] = 1;
                    end
                    if (ordy[g]) begin rp[g]++; seen[g] = 0; end
                end
            end else if (rp[g] != wp[g]) begin
                chk("busy", g, 64'(bsy[g]), 64'(cyc > e_cyc[g][rp[g] % 256]));
            end
            hold[g]     = ov[g] && !ordy[g];
            prev_res[g] = res[g];
        end
    end

    task automatic issue(logic [1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
        bit taken[2];
        @(negedge clk);
        mul_op = op; alu_a = a; alu_b = b;
        iv[0] = 1'b1; iv[1] = 1'b1; taken[0] = 0; taken[1] = 0;
        for (int t = 0; t < 800 && (iv[0] || iv[1]); t++) begin
            for (int g = 0; g < 2; g++) begin
                if (iv[g]) begin
                    if (taken[g]) iv[g] = 1'b0;
                    else if (ir[g]) begin
                        e_res[g][wp[g] % 256] = model(op, a, b);
                        e_cyc[g][wp[g] % 256] = cyc;
                        wp[g]++;
                        taken[g] = 1;
                    end
                end
            end
            if (iv[0] || iv[1]) @(negedge clk);
        end
        for (int g = 0; g < 2; g++) begin
            if (iv[g]) begin
                chk("accept_timeout", g, 64'(iv[g]), 64'd0);
                iv[g] = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((rp[0] != wp[0] || rp[1] != wp[1]) && t < 1000) begin
            @(negedge clk); t++;
        end
        for (int g = 0; g < 2; g++) if (rp[g] != wp[g]) chk("drain_timeout", g, 64'(wp[g] - rp[g]), 64'd0);
        @(negedge clk);
    endtask

    task automatic reset_checks();
        for (int g = 0; g < 2; g++) begin
            chk("rst_in_ready", g, 64'(ir[g]), 64'd0);
            chk("rst_out_valid", g, 64'(ov[g]), 64'd0);
            chk("rst_busy", g, 64'(bsy[g]), 64'd0);
            chk("rst_alu_res", g, 64'(res[g]), 64'd0);
        end
        rst_n = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) chk("post_rst_in_ready", g, 64'(ir[g]), 64'd1);
    endtask

    bit b_done;
    logic [DW-1:0] corner[6];

    initial begin
        rst_n = 1'b0; mul_op = 2'b00; alu_a = '0; alu_b = '0;
        iv[0] = 1'b0; iv[1] = 1'b0; ordy_force[0] = 1'b1; ordy_force[1] = 1'b1; rnd_ordy = 0;
        wp[0] = 0; wp[1] = 0; rp[0] = 0; rp[1] = 0;
        repeat (2) @(negedge clk);
        reset_checks();

        issue(2'b00, 32'd7, 32'd6);
        drain();
        for (int op = 0; op < 4; op++) issue(2'(op), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'b11, 32'h0, 32'h0);
        drain();

        // Backpressure with a new operand pair pending at the input.
        ordy_force[0] = 1'b0; ordy_force[1] = 1'b0;
        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        for (int t = 0; t < 80 && !(ov[0] && ov[1]); t++) @(negedge clk);
        for (int g = 0; g < 2; g++) chk("bp_valid", g, 64'(ov[g]), 64'd1);
        b_done = 0;
        fork
            begin issue(2'b00, 32'd11, 32'd13); b_done = 1; end
        join_none
        repeat (5) @(negedge clk);
        for (int g = 0; g < 2; g++) chk("bp_no_capture", g, 64'(wp[g] - rp[g]), 64'd1);
        ordy_force[0] = 1'b1; ordy_force[1] = 1'b1;
        for (int t = 0; t < 100 && !b_done; t++) @(negedge clk);
        chk("bp_second_accept", 0, 64'(b_done), 64'd1);
        drain();

        // Reset mid-BUSY (STEP=1) and mid-DONE (STEP=4 held by backpressure).
        ordy_force[1] = 1'b0;
        issue(2'b00, 32'd123, 32'd456);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        reset_checks();
        ordy_force[1] = 1'b1;
        issue(2'b00, 32'd3, 32'd5);
        drain();

        corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF; corner[5] = 32'h0000_FFFF;
        rnd_ordy = 1;
        for (int k = 0; k < 40; k++) begin
            logic [DW-1:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            issue(2'($urandom_range(0, 3)), a, b);
        end
        drain();
        rnd_ordy = 0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
